// File: rtl/polygon_scan.sv
// Polygon bounding-box scanner: folds the vertex list into a signed bounding box,
// then streams every integer point of that box row-major under ready/valid.
module polygon_scan #(
  parameter int MAX_NUM_VERTICES = 8,
  parameter int WORLD_BITS       = 18,
  localparam int NUM_W           = $clog2(MAX_NUM_VERTICES + 1),
  localparam int IDX_W           = (MAX_NUM_VERTICES > 1) ? $clog2(MAX_NUM_VERTICES) : 1
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         start_in,
  input  logic signed [WORLD_BITS-1:0] poly_xs_in [MAX_NUM_VERTICES],
  input  logic signed [WORLD_BITS-1:0] poly_ys_in [MAX_NUM_VERTICES],
  input  logic        [NUM_W-1:0]      num_points_in,
  input  logic                         ready_in,
  output logic signed [WORLD_BITS-1:0] x_out,
  output logic signed [WORLD_BITS-1:0] y_out,
  output logic                         valid_out,
  output logic                         last_out,
  output logic                         busy_out,
  output logic                         done_out,
  output logic                         error_out
);

  typedef enum logic [1:0] {IDLE, BBOX, SCAN} state_t;

  state_t r_state;
  state_t w_next_state;

  logic signed [WORLD_BITS-1:0] r_xs [MAX_NUM_VERTICES];
  logic signed [WORLD_BITS-1:0] r_ys [MAX_NUM_VERTICES];
  logic        [NUM_W-1:0]      r_num;
  logic        [IDX_W-1:0]      r_idx;
  logic signed [WORLD_BITS-1:0] r_xmin, r_xmax, r_ymin, r_ymax;
  logic signed [WORLD_BITS-1:0] r_x, r_y;
  logic                         r_done;
  logic                         r_error;

  logic                         w_start_ok;
  logic                         w_first;
  logic                         w_fold_last;
  logic signed [WORLD_BITS-1:0] w_vx, w_vy;
  logic signed [WORLD_BITS-1:0] w_xmin_new, w_xmax_new, w_ymin_new, w_ymax_new;
  logic                         w_at_xmax, w_at_ymax;
  logic                         w_xfer;

  assign w_start_ok  = start_in && (num_points_in >= NUM_W'(3)) &&
                       (num_points_in <= NUM_W'(MAX_NUM_VERTICES));
  assign w_first     = (r_idx == '0);
  assign w_fold_last = (NUM_W'(r_idx) == (r_num - NUM_W'(1)));
  assign w_vx        = r_xs[r_idx];
  assign w_vy        = r_ys[r_idx];

  // Vertex 0 seeds the box so stale extents from a previous scan never leak in.
  assign w_xmin_new  = (w_first || (w_vx < r_xmin)) ? w_vx : r_xmin;
  assign w_xmax_new  = (w_first || (w_vx > r_xmax)) ? w_vx : r_xmax;
  assign w_ymin_new  = (w_first || (w_vy < r_ymin)) ? w_vy : r_ymin;
  assign w_ymax_new  = (w_first || (w_vy > r_ymax)) ? w_vy : r_ymax;

  assign w_at_xmax   = (r_x == r_xmax);
  assign w_at_ymax   = (r_y == r_ymax);
  assign w_xfer      = (r_state == SCAN) && ready_in;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_start_ok) w_next_state = BBOX;
      BBOX:    if (w_fold_last) w_next_state = SCAN;
      SCAN:    if (w_xfer && w_at_xmax && w_at_ymax) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Snapshot is pure data; it is only read after a start has loaded it.
  always_ff @(posedge clk_in) begin
    if (r_state == IDLE && w_start_ok) begin
      r_xs <= poly_xs_in;
      r_ys <= poly_ys_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_num   <= '0;
      r_idx   <= '0;
      r_xmin  <= '0;
      r_xmax  <= '0;
      r_ymin  <= '0;
      r_ymax  <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_in) begin
            if (w_start_ok) begin
              r_num <= num_points_in;
              r_idx <= '0;
            end else begin
              r_error <= 1'b1;
            end
          end
        end
        BBOX: begin
          r_xmin <= w_xmin_new;
          r_xmax <= w_xmax_new;
          r_ymin <= w_ymin_new;
          r_ymax <= w_ymax_new;
          r_idx  <= r_idx + 1'b1;
          if (w_fold_last) begin
            r_x <= w_xmin_new;
            r_y <= w_ymin_new;
          end
        end
        SCAN: begin
          // Compare against the max before stepping so the counters never overflow.
          if (w_xfer) begin
            if (!w_at_xmax) begin
              r_x <= r_x + 1'b1;
            end else if (!w_at_ymax) begin
              r_x <= r_xmin;
              r_y <= r_y + 1'b1;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign x_out     = r_x;
  assign y_out     = r_y;
  assign valid_out = (r_state == SCAN);
  assign last_out  = (r_state == SCAN) && w_at_xmax && w_at_ymax;
  assign busy_out  = (r_state != IDLE);
  assign done_out  = r_done;
  assign error_out = r_error;

endmodule
